// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: buffers two image rows and emits every fully
// populated neighbourhood as nine non-negative 9-bit signed operands.
module conv_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_in,
  output logic              pix_ready,
  output logic signed [8:0] win [0:8],
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              frame_done
);
  // state | meaning
  // IDLE  | waiting for start, no pixels accepted
  // RUN   | accepting pixels, emitting windows
  // DRAIN | last pixel taken, waiting for final window handshake
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    line1 [IMG_W];
  logic [7:0]    line2 [IMG_W];
  logic [7:0]    w [9];
  logic [7:0]    l1_rd, l2_rd;
  logic          accept, handshake, makes_win;

  assign pix_ready = (state == RUN) && (!win_valid || win_ready);
  // A start in the same cycle drops the offered pixel.
  assign accept    = pix_valid && pix_ready && !start;
  assign handshake = win_valid && win_ready;
  assign busy      = (state != IDLE);
  assign l1_rd     = line1[col];
  assign l2_rd     = line2[col];
  assign makes_win = (row >= RW'(2)) && (col >= CW'(2));

  always_comb begin
    for (int i = 0; i < 9; i++) win[i] = {1'b0, w[i]};
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      line2[col] <= l1_rd;
      line1[col] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) w[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        state     <= RUN;
        col       <= '0;
        row       <= '0;
        win_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            if (accept) begin
              w[0] <= w[1]; w[1] <= w[2]; w[2] <= l2_rd;
              w[3] <= w[4]; w[4] <= w[5]; w[5] <= l1_rd;
              w[6] <= w[7]; w[7] <= w[8]; w[8] <= pix_in;
              win_valid <= makes_win;
              if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                if (row == RW'(IMG_H - 1)) state <= DRAIN;
                else                       row   <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end else if (handshake) begin
              win_valid <= 1'b0;
            end
          end
          DRAIN: begin
            if (handshake) begin
              win_valid  <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on a 5x4 frame: windows are checked against a
// reference built directly from the image array.
module tb_conv_window_gen;
  localparam int W = 5, H = 4, NPIX = W * H;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_valid = 1'b0, win_ready = 1'b0;
  logic [7:0] pix_in = '0;
  logic pix_ready, win_valid, busy, frame_done;
  logic signed [8:0] win [0:8];

  int pass_cnt = 0, total = 0;
  int img [NPIX];
  logic [80:0] got [$];
  logic [80:0] exp_q [$];
  int done_cnt, done_cyc, hold_bad, ready_bad, busy_bad, hold_cycles;
  bit timeout;
  logic after_abort_wv, after_abort_busy;

  conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .win(win), .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [80:0] pack_win();
    logic [80:0] p;
    for (int k = 0; k < 9; k++) p[9*k +: 9] = win[k];
    return p;
  endfunction

  function automatic logic [80:0] ref_win(int r, int c);
    logic [80:0] p;
    for (int k = 0; k < 9; k++) p[9*k +: 9] = 9'(img[(r - 2 + k / 3) * W + (c - 2 + k % 3)]);
    return p;
  endfunction

  function automatic logic [80:0] from_list(int v[9]);
    logic [80:0] p;
    for (int k = 0; k < 9; k++) p[9*k +: 9] = 9'(v[k]);
    return p;
  endfunction

  function automatic void build_expected();
    exp_q.delete();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) exp_q.push_back(ref_win(r, c));
  endfunction

  function automatic void fill_ramp();
    for (int i = 0; i < NPIX; i++) img[i] = 5 * (i / W) + (i % W);
  endfunction

  task automatic run_frame(input int pv_pct, input int wr_pct, input int hold_first,
                           input int abort_at, input int budget);
    int idx, cyc, hold_left, post;
    bit held, prev_stall, done_seen;
    logic [80:0] prev_win, cur;
    got.delete();
    done_cnt = 0; done_cyc = -1; hold_bad = 0; ready_bad = 0; busy_bad = 0;
    hold_cycles = 0; timeout = 0;
    @(negedge clk); start = 1'b1; pix_valid = 1'b0; win_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    idx = 0; cyc = 0; hold_left = 0; post = 0; held = 0; prev_stall = 0; done_seen = 0;
    prev_win = '0;
    while (post < 3 && cyc < budget) begin
      if (abort_at >= 0 && idx == abort_at) begin
        start = 1'b1; pix_valid = 1'b1; pix_in = 8'(img[idx]); win_ready = 1'b0;
        abort_at = -1;
        @(negedge clk);
        start = 1'b0; pix_valid = 1'b0;
        after_abort_wv = win_valid; after_abort_busy = busy;
        idx = 0; got.delete(); prev_stall = 0; cyc++;
        continue;
      end
      if (hold_first > 0 && !held && win_valid) begin held = 1; hold_left = hold_first; end
      if (hold_left > 0) begin
        win_ready = 1'b0; hold_left--; hold_cycles++;
      end else begin
        win_ready = int'($urandom_range(99)) < wr_pct;
      end
      pix_valid = (idx < NPIX) && (int'($urandom_range(99)) < pv_pct);
      pix_in = (idx < NPIX) ? 8'(img[idx]) : 8'($urandom);
      #1;
      cur = pack_win();
      if (prev_stall && (cur !== prev_win || win_valid !== 1'b1)) hold_bad++;
      if (win_valid && !win_ready && pix_ready) hold_bad++;
      if (busy && !win_valid && !pix_ready) ready_bad++;
      if (win_valid && win_ready) got.push_back(cur);
      if (pix_valid && pix_ready) idx++;
      if (frame_done) begin
        done_cnt++;
        if (!done_seen) done_cyc = cyc;
        done_seen = 1;
        if (busy) busy_bad++;
      end
      prev_stall = win_valid && !win_ready;
      prev_win = cur;
      if (done_seen) post++;
      @(negedge clk);
      cyc++;
    end
    pix_valid = 1'b0; win_ready = 1'b0;
    if (!done_seen) timeout = 1;
  endtask

  task automatic test_reset();
    total++; if (pix_ready !== 1'b0) $display("FAIL reset_pix_ready got %b want 0", pix_ready); else pass_cnt++;
    total++; if (win_valid !== 1'b0) $display("FAIL reset_win_valid got %b want 0", win_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else pass_cnt++;
    total++; if (pack_win() !== 81'd0) $display("FAIL reset_win got %h want 0", pack_win()); else pass_cnt++;
  endtask

  task automatic test_basic();
    int v[9];
    int bad;
    fill_ramp(); build_expected();
    run_frame(100, 100, 0, -1, 500);
    total++; if (timeout) $display("FAIL basic_timeout got timeout want frame_done"); else pass_cnt++;
    total++; if (got.size() !== 6) $display("FAIL basic_count got %0d want 6", got.size()); else pass_cnt++;
    v = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    total++; if (got.size() < 1 || got[0] !== from_list(v))
      $display("FAIL basic_first got %h want %h", got.size() > 0 ? got[0] : 81'd0, from_list(v)); else pass_cnt++;
    v = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
    total++; if (got.size() < 6 || got[5] !== from_list(v))
      $display("FAIL basic_last got %h want %h", got.size() > 5 ? got[5] : 81'd0, from_list(v)); else pass_cnt++;
    total++; if (done_cnt !== 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt); else pass_cnt++;
    total++; if (done_cyc !== NPIX + 1) $display("FAIL basic_throughput got done at %0d want %0d", done_cyc, NPIX + 1); else pass_cnt++;
    total++; if (ready_bad !== 0 || busy_bad !== 0) $display("FAIL basic_ready_busy got %0d/%0d want 0/0", ready_bad, busy_bad); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
    total++; if (bad !== 0) $display("FAIL basic_windows got %0d wrong want 0", bad); else pass_cnt++;
  endtask

  task automatic test_row_wrap();
    int v[9];
    fill_ramp();
    run_frame(50, 100, 0, -1, 1000);
    v = '{5, 6, 7, 10, 11, 12, 15, 16, 17};
    total++; if (got.size() !== 6) $display("FAIL wrap_count got %0d want 6", got.size()); else pass_cnt++;
    total++; if (got.size() < 4 || got[3] !== from_list(v))
      $display("FAIL wrap_window got %h want %h", got.size() > 3 ? got[3] : 81'd0, from_list(v)); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int bad;
    fill_ramp(); build_expected();
    run_frame(100, 100, 4, -1, 500);
    total++; if (hold_cycles !== 4) $display("FAIL bp_hold_cycles got %0d want 4", hold_cycles); else pass_cnt++;
    total++; if (hold_bad !== 0) $display("FAIL bp_hold got %0d violations want 0", hold_bad); else pass_cnt++;
    total++; if (got.size() !== 6) $display("FAIL bp_count got %0d want 6", got.size()); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
    total++; if (bad !== 0) $display("FAIL bp_windows got %0d wrong want 0", bad); else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NPIX; i++) img[i] = 255;
    run_frame(70, 70, 0, -1, 2000);
    total++; if (got.size() !== 6) $display("FAIL sat_count got %0d want 6", got.size()); else pass_cnt++;
    for (int i = 0; i < got.size(); i++) begin
      total++; if (got[i] !== {9{9'h0FF}}) $display("FAIL sat_window%0d got %h want all 0ff", i, got[i]); else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    int bad;
    fill_ramp(); build_expected();
    run_frame(100, 100, 0, 13, 500);
    total++; if (after_abort_wv !== 1'b0 || after_abort_busy !== 1'b1)
      $display("FAIL abort_state got wv=%b busy=%b want wv=0 busy=1", after_abort_wv, after_abort_busy); else pass_cnt++;
    total++; if (done_cnt !== 1) $display("FAIL abort_done_pulses got %0d want 1", done_cnt); else pass_cnt++;
    total++; if (got.size() !== 6) $display("FAIL abort_count got %0d want 6", got.size()); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
    total++; if (bad !== 0) $display("FAIL abort_windows got %0d wrong want 0", bad); else pass_cnt++;
  endtask

  task automatic test_random();
    int bad;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
      build_expected();
      run_frame(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)), 0, -1, 3000);
      bad = 0;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
      total++; if (timeout || done_cnt !== 1) $display("FAIL rand%0d_done got %0d pulses want 1", f, done_cnt); else pass_cnt++;
      total++; if (got.size() !== exp_q.size() || bad !== 0)
        $display("FAIL rand%0d_windows got %0d windows %0d wrong want %0d windows 0 wrong", f, got.size(), bad, exp_q.size()); else pass_cnt++;
      total++; if (hold_bad !== 0 || ready_bad !== 0)
        $display("FAIL rand%0d_handshake got %0d/%0d violations want 0/0", f, hold_bad, ready_bad); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    fill_ramp(); build_expected();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; pix_valid = 1'b1; win_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin pix_in = 8'(img[i]); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || pix_ready !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL midrst_outputs got busy=%b rdy=%b wv=%b fd=%b want 0000", busy, pix_ready, win_valid, frame_done); else pass_cnt++;
    total++; if (pack_win() !== 81'd0) $display("FAIL midrst_win got %h want 0", pack_win()); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (pix_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    pix_valid = 1'b0;
    total++; if (bad !== 0) $display("FAIL midrst_idle got %0d active cycles want 0", bad); else pass_cnt++;
    run_frame(100, 100, 0, -1, 500);
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
    total++; if (got.size() !== 6 || bad !== 0 || done_cnt !== 1)
      $display("FAIL midrst_frame got %0d windows %0d wrong %0d done want 6/0/1", got.size(), bad, done_cnt); else pass_cnt++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 test_reset();
    rst_n = 1'b1;
    @(negedge clk); #1;
    test_reset();
    test_basic();
    test_row_wrap();
    test_backpressure();
    test_saturation();
    test_abort();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
